// File: rtl/n64_flashram_executor.sv
// Executes FlashRAM page writes, sector erases and chip erases against the SDRAM
// save region through a single 32-bit write master, one word per acknowledged request.
module n64_flashram_executor #(
  parameter logic [26:0] FLASHRAM_BASE = 27'h3FE_0000,
  parameter logic [31:0] ERASE_DATA    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        operation_pending,
  input  logic        write_or_erase,
  input  logic        sector_or_all,
  input  logic [9:0]  sector,
  output logic        operation_done,
  output logic [4:0]  buffer_address,
  input  logic [31:0] buffer_rdata,
  output logic        mem_request,
  input  logic        mem_ack,
  output logic [26:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BUF_ADDR   = 3'd1,
    S_BUF_DATA   = 3'd2,
    S_MEM        = 3'd3,
    S_DONE       = 3'd4,
    S_WAIT_CLEAR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] counter_q, counter_d;
  logic        is_erase_q, is_erase_d;
  logic        is_all_q, is_all_d;
  logic [9:0]  sector_q, sector_d;
  logic        done_q, done_d;
  logic        request_q, request_d;
  logic        busy_q, busy_d;
  logic [4:0]  buf_addr_q, buf_addr_d;
  logic [26:0] address_q, address_d;
  logic [31:0] wdata_q, wdata_d;
  logic [14:0] last_count_s;

  // The region is 128 KiB aligned, so the word offset is simply concatenated below the base.
  function automatic logic [26:0] word_addr(input logic       is_erase,
                                            input logic       is_all,
                                            input logic [9:0] sec,
                                            input logic [14:0] cnt);
    logic [16:0] offset;
    if (!is_erase) begin
      offset = {sec, cnt[4:0], 2'b00};
    end else if (!is_all) begin
      offset = {sec[9:7], cnt[11:0], 2'b00};
    end else begin
      offset = {cnt[14:0], 2'b00};
    end
    return {FLASHRAM_BASE[26:17], offset};
  endfunction

  always_comb begin
    if (!is_erase_q) begin
      last_count_s = 15'd31;
    end else if (!is_all_q) begin
      last_count_s = 15'd4095;
    end else begin
      last_count_s = 15'd32767;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    is_erase_d = is_erase_q;
    is_all_d   = is_all_q;
    sector_d   = sector_q;
    done_d     = 1'b0;
    request_d  = request_q;
    buf_addr_d = buf_addr_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (operation_pending) begin
          is_erase_d = write_or_erase;
          is_all_d   = sector_or_all;
          sector_d   = sector;
          counter_d  = 15'd0;
          buf_addr_d = 5'd0;
          if (!write_or_erase) begin
            state_d = S_BUF_ADDR;
          end else begin
            state_d   = S_MEM;
            request_d = 1'b1;
            address_d = word_addr(1'b1, sector_or_all, sector, 15'd0);
            wdata_d   = ERASE_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUF_ADDR: begin
        state_d = S_BUF_DATA;
      end
      S_BUF_DATA: begin
        wdata_d   = buffer_rdata;
        request_d = 1'b1;
        address_d = word_addr(is_erase_q, is_all_q, sector_q, counter_q);
        state_d   = S_MEM;
      end
      S_MEM: begin
        // Request was dropped for one cycle after the previous ack; re-arm with the next word.
        if (!request_q) begin
          request_d = 1'b1;
          address_d = word_addr(is_erase_q, is_all_q, sector_q, counter_q);
        end else if (mem_ack) begin
          request_d = 1'b0;
          counter_d = counter_q + 15'd1;
          if (counter_q == last_count_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (!is_erase_q) begin
            state_d    = S_BUF_ADDR;
            buf_addr_d = counter_q[4:0] + 5'd1;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          request_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR: begin
        if (!operation_pending) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_CLEAR;
        end
      end
      default: begin
        state_d   = S_IDLE;
        request_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      counter_q  <= 15'd0;
      is_erase_q <= 1'b0;
      is_all_q   <= 1'b0;
      sector_q   <= 10'd0;
      done_q     <= 1'b0;
      request_q  <= 1'b0;
      busy_q     <= 1'b0;
      buf_addr_q <= 5'd0;
      address_q  <= FLASHRAM_BASE;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      is_erase_q <= is_erase_d;
      is_all_q   <= is_all_d;
      sector_q   <= sector_d;
      done_q     <= done_d;
      request_q  <= request_d;
      busy_q     <= busy_d;
      buf_addr_q <= buf_addr_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
    end
  end

  assign operation_done = done_q;
  assign buffer_address = buf_addr_q;
  assign mem_request    = request_q;
  assign mem_address    = address_q;
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_n64_flashram_executor.sv
// Directed bench for n64_flashram_executor: a memory responder logs every acknowledged
// write and per-scenario tasks compare the log against hand-computed addresses and data.
module tb_n64_flashram_executor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        operation_pending;
  logic        write_or_erase;
  logic        sector_or_all;
  logic [9:0]  sector;
  logic        operation_done;
  logic [4:0]  buffer_address;
  logic [31:0] buffer_rdata;
  logic        mem_request;
  logic        mem_ack;
  logic [26:0] mem_address;
  logic [31:0] mem_wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] buf_mem [32];
  logic [26:0] log_addr [$];
  logic [31:0] log_data [$];
  int cyc = 0, done_count = 0, done_cyc = 0, last_ack_cyc = 0;
  int ack_delay = 0, stall_word = -1, stall_len = 0, wait_cnt = 0;
  int unstable = 0, held = 0, max_held = 0;
  logic        prev_req = 1'b0;
  logic [26:0] prev_addr;
  logic [31:0] prev_data;

  n64_flashram_executor dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .operation_pending (operation_pending),
    .write_or_erase    (write_or_erase),
    .sector_or_all     (sector_or_all),
    .sector            (sector),
    .operation_done    (operation_done),
    .buffer_address    (buffer_address),
    .buffer_rdata      (buffer_rdata),
    .mem_request       (mem_request),
    .mem_ack           (mem_ack),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Registered page-buffer read port.
  always @(posedge clk) buffer_rdata <= buf_mem[buffer_address];

  // Memory responder and monitors, evaluated away from the active edge.
  always @(negedge clk) begin
    int need;
    cyc++;
    if (!reset_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      prev_req = 1'b0;
      held     = 0;
    end else begin
      if (operation_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (mem_request && prev_req) begin
        held++;
        if (held > max_held) max_held = held;
        if (mem_address !== prev_addr || mem_wdata !== prev_data) unstable++;
      end else begin
        held = 0;
      end
      prev_req  = mem_request;
      prev_addr = mem_address;
      prev_data = mem_wdata;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_request) begin
        need = (log_addr.size() == stall_word) ? stall_len : ack_delay;
        if (wait_cnt >= need) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          log_addr.push_back(mem_address);
          log_data.push_back(mem_wdata);
          last_ack_cyc = cyc;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    done_count = 0;
    unstable   = 0;
    max_held   = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (done_count >= 1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present a request for one cycle (or hold it), then scramble the fields to prove latching.
  task automatic start_op(input logic woe, input logic soa, input logic [9:0] sec, input bit hold);
    operation_pending = 1'b1;
    write_or_erase    = woe;
    sector_or_all     = soa;
    sector            = sec;
    cycles(1);
    if (!hold) operation_pending = 1'b0;
    write_or_erase = ~woe;
    sector_or_all  = ~soa;
    sector         = ~sec;
  endtask

  function automatic int count_bad(input logic [26:0] base, input int n, input bit from_buf);
    int bad = 0;
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      if (i >= log_addr.size()) begin
        bad++;
      end else begin
        exp = from_buf ? (32'hA5A5_0000 + i) : 32'hFFFF_FFFF;
        if (log_addr[i] !== base + 27'(4 * i) || log_data[i] !== exp) bad++;
      end
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    checks++; if (operation_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", operation_done); end
    checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL reset_request got %0b want 0", mem_request); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (buffer_address !== 5'd0) begin errors++; $display("FAIL reset_buf_addr got %0d want 0", buffer_address); end
    checks++; if (mem_address !== 27'h3FE_0000) begin errors++; $display("FAIL reset_address got %h want 3fe0000", mem_address); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_page_write();
    bit ok;
    int bad;
    clear_logs();
    ack_delay = 2;
    start_op(1'b0, 1'b0, 10'h003, 1'b0);
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL page_done_timeout got none want pulse"); end
    cycles(5);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL page_done_count got %0d want 1", done_count); end
    checks++; if (log_addr.size() !== 32) begin errors++; $display("FAIL page_writes got %0d want 32", log_addr.size()); end
    bad = count_bad(27'h3FE_0180, 32, 1'b1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL page_content got %0d bad words want 0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL page_busy_after got %0b want 0", busy); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL page_stable got %0d changes want 0", unstable); end
    ack_delay = 0;
  endtask

  task automatic test_sector_erase();
    bit ok;
    int bad;
    clear_logs();
    start_op(1'b1, 1'b0, 10'h1C5, 1'b0);
    wait_done(12000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sector_done_timeout got none want pulse"); end
    cycles(5);
    checks++; if (log_addr.size() !== 4096) begin errors++; $display("FAIL sector_writes got %0d want 4096", log_addr.size()); end
    bad = count_bad(27'h3FE_C000, 4096, 1'b0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL sector_content got %0d bad words want 0", bad); end
    if (log_addr.size() > 0) begin
      checks++; if (log_addr[log_addr.size()-1] !== 27'h3FE_FFFC) begin errors++; $display("FAIL sector_last_addr got %h want 3fefffc", log_addr[log_addr.size()-1]); end
    end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL sector_done_count got %0d want 1", done_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    clear_logs();
    stall_word = 5;
    stall_len  = 50;
    start_op(1'b0, 1'b0, 10'h000, 1'b0);
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got none want pulse"); end
    cycles(3);
    checks++; if (log_addr.size() !== 32) begin errors++; $display("FAIL bp_writes got %0d want 32", log_addr.size()); end
    bad = count_bad(27'h3FE_0000, 32, 1'b1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_content got %0d bad words want 0", bad); end
    checks++; if (max_held < 50) begin errors++; $display("FAIL bp_held got %0d cycles want >=50", max_held); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    stall_word = -1;
  endtask

  task automatic test_sticky_pending();
    bit ok;
    int bad;
    clear_logs();
    start_op(1'b0, 1'b0, 10'h3FF, 1'b1);
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sticky_done_timeout got none want pulse"); end
    cycles(10);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL sticky_done_count got %0d want 1", done_count); end
    checks++; if (log_addr.size() !== 32) begin errors++; $display("FAIL sticky_writes got %0d want 32", log_addr.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sticky_busy_held got %0b want 1", busy); end
    operation_pending = 1'b0;
    cycles(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sticky_busy_clear got %0b want 0", busy); end
    clear_logs();
    start_op(1'b0, 1'b0, 10'h3FF, 1'b0);
    wait_done(3000, ok);
    cycles(3);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL sticky_second_done got %0d want 1", done_count); end
    bad = count_bad(27'h3FF_FF80, 32, 1'b1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL sticky_second_content got %0d bad words want 0", bad); end
  endtask

  task automatic test_chip_erase();
    bit ok;
    int bad;
    clear_logs();
    start_op(1'b1, 1'b1, 10'h155, 1'b0);
    wait_done(70000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chip_done_timeout got none want pulse"); end
    checks++; if (done_cyc !== last_ack_cyc + 1) begin errors++; $display("FAIL chip_done_timing got cycle %0d want %0d", done_cyc, last_ack_cyc + 1); end
    cycles(5);
    checks++; if (log_addr.size() !== 32768) begin errors++; $display("FAIL chip_writes got %0d want 32768", log_addr.size()); end
    bad = count_bad(27'h3FE_0000, 32768, 1'b0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL chip_content got %0d bad words want 0", bad); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL chip_done_count got %0d want 1", done_count); end
  endtask

  task automatic test_reset_mid_erase();
    bit ok;
    int bad;
    clear_logs();
    start_op(1'b1, 1'b0, 10'h080, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cycles(1);
      if (log_addr.size() >= 100 && mem_request === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach got %0d words want 100", log_addr.size()); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rst_mid_request got %0b want 0", mem_request); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    cycles(3);
    reset_n = 1'b1;
    cycles(20);
    checks++; if (done_count !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", done_count); end
    clear_logs();
    start_op(1'b0, 1'b0, 10'h001, 1'b0);
    wait_done(3000, ok);
    cycles(3);
    checks++; if (done_count !== 1) begin errors++; $display("FAIL rst_after_done got %0d want 1", done_count); end
    bad = count_bad(27'h3FE_0080, 32, 1'b1);
    checks++; if (bad !== 0 || log_addr.size() !== 32) begin errors++; $display("FAIL rst_after_content got %0d bad of %0d words want 0 of 32", bad, log_addr.size()); end
  endtask

  initial begin
    reset_n           = 1'b0;
    operation_pending = 1'b0;
    write_or_erase    = 1'b0;
    sector_or_all     = 1'b0;
    sector            = 10'd0;
    for (int i = 0; i < 32; i++) buf_mem[i] = 32'hA5A5_0000 + i;
    test_reset();
    test_page_write();
    test_sector_erase();
    test_backpressure();
    test_sticky_pending();
    test_chip_erase();
    test_reset_mid_erase();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n64_flashram_executor.md
Name: n64_flashram_executor

Overview:
- Downstream consumer of the N64 FlashRAM command front-end.
- Picks up each pending operation (page write, sector erase or chip erase) and performs it against the 128 KiB FlashRAM save region in SDRAM through a single 32-bit memory master port.
- For page writes, reads the 32-word page buffer through the front-end's synchronous read port.
- Signals completion with a one-cycle done pulse back to the front-end.

Parameters:
- FLASHRAM_BASE, 27'h3FE_0000, byte address of the FlashRAM region in SDRAM; must be 128 KiB aligned.
- ERASE_DATA, 32'hFFFF_FFFF, word written to every location during an erase.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- operation_pending  in  1  level from front-end; an operation is requested while high.
- write_or_erase  in  1  0 = page write, 1 = erase; valid while operation_pending is high.
- sector_or_all  in  1  for erase: 0 = sector, 1 = whole chip.
- sector  in  10  page number (write) or any page within the target sector (erase).
- operation_done  out  1  one-cycle completion pulse.
- buffer_address  out  5  page-buffer word index.
- buffer_rdata  in  32  page-buffer data; registered, valid 1 cycle after buffer_address.
- mem_request  out  1  memory write request.
- mem_ack  in  1  one-cycle acknowledge from the memory arbiter.
- mem_address  out  27  byte address, bits [1:0] always 0.
- mem_wdata  out  32  write data.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset values (async, reset_n low): state S_IDLE; operation_done 0; mem_request 0; busy 0; buffer_address 0; mem_address FLASHRAM_BASE; mem_wdata 0; counter 0.
- Reset mid-operation aborts immediately: mem_request drops, nothing completes, no operation_done is emitted.

State machine:
- S_IDLE: on operation_pending=1, latch write_or_erase, sector_or_all and sector, clear the word counter, then go to:
  - S_BUF_ADDR for a write;
  - S_MEM for an erase.
- S_BUF_ADDR:
  - drive buffer_address = counter[4:0];
  - next cycle go to S_BUF_DATA.
- S_BUF_DATA:
  - capture buffer_rdata into mem_wdata;
  - go to S_MEM.
- S_MEM:
  - hold mem_request=1 with stable mem_address and mem_wdata until a cycle in which mem_ack=1;
  - in that cycle deassert mem_request and increment the counter;
  - if this was the last word go to S_DONE;
  - otherwise go to S_BUF_ADDR (write) or stay in S_MEM (erase) and re-assert mem_request the following cycle. mem_request is low for at least one cycle between words.
- S_DONE:
  - operation_done=1 for exactly this cycle;
  - go to S_WAIT_CLEAR.
- S_WAIT_CLEAR:
  - stay until operation_pending=0, then go to S_IDLE.
  - This guarantees one operation per pending assertion, even if pending is still high in the cycle after done.

Addressing (counter is 15 bits; word offset is relative to FLASHRAM_BASE):
- Page write:
  - 32 words;
  - mem_address = FLASHRAM_BASE + {sector, 7'b0} + {counter[4:0], 2'b00};
  - data comes from the buffer.
- Sector erase:
  - 4096 words (16 KiB);
  - base = FLASHRAM_BASE + {latched sector[9:7], 14'b0};
  - sector[6:0] is ignored;
  - data = ERASE_DATA.
- Chip erase:
  - 32768 words (128 KiB);
  - base = FLASHRAM_BASE;
  - data = ERASE_DATA.
- Address arithmetic never leaves the 128 KiB region; the last word is counter = N-1.
- Latched fields are used for the whole operation. Input changes mid-operation have no effect.
- mem_ack outside S_MEM is ignored.
- operation_pending dropping mid-operation does not abort; the operation completes and the done pulse is still emitted.
- Memory writes are full 32-bit writes; no read-modify-write.

Test Plan:
- Page write: preload buffer word i = 32'hA5A5_0000+i; pulse pending with write_or_erase=0, sector=10'h003, mem_ack 2 cycles after each request -> 32 writes to 27'h3FE_0180..27'h3FE_01FC with matching data in order; single operation_done; busy low after pending clears.
- Sector erase: write_or_erase=1, sector_or_all=0, sector=10'h1C5 (sector 3) -> 4096 writes of 32'hFFFF_FFFF from 27'h3FE_C000 to 27'h3FE_FFFC; nothing outside that range.
- Chip erase: sector_or_all=1 -> 32768 writes covering 27'h3FE_0000..27'h3FF_FFFC; exactly one operation_done after the final mem_ack.
- Back-pressure: hold mem_ack low for 50 cycles on word 5 -> mem_request, mem_address and mem_wdata stable throughout; no duplicate or skipped words.
- Sticky pending: keep operation_pending high 10 cycles after operation_done -> no second operation; a new pending pulse afterwards starts a fresh operation.
- Reset mid-erase: assert reset_n=0 at word 100 -> mem_request and busy fall asynchronously; no operation_done; a subsequent operation after reset runs normally.
